// File: rtl/x_top_uart_pkg.sv
// x_top_uart_pkg
//   Shared types for the UART transmit path and its arbiter.
//   sm_arb_t : arbiter state (ARB picks a requester, SEND holds a frame)
//   byte_t   : one UART payload byte
//   rr_wrap  : modular index helper for round-robin scans
package x_top_uart_pkg;

  typedef enum logic {
    ARB  = 1'b0,
    SEND = 1'b1
  } sm_arb_t;

  typedef logic [7:0] byte_t;

  // (base + offs) mod n for base < n and offs < n, without a divider
  function automatic int rr_wrap(input int base, input int offs, input int n);
    int s;
    s = base + offs;
    return (s >= n) ? (s - n) : s;
  endfunction

endpackage

// File: rtl/x_top_rr_pick.sv
// x_top_rr_pick
//   Combinational round-robin picker: returns the first set bit of i_req
//   scanning from i_ptr upward and wrapping at p_num-1.
// Ports
//   i_req   in  p_num    request vector
//   i_ptr   in  p_idx_w  scan start index (must be < p_num)
//   o_pick  out p_num    one-hot pick, zero when no request
//   o_idx   out p_idx_w  index of the picked request
//   o_any   out 1        at least one request present
module x_top_rr_pick
  import x_top_uart_pkg::*;
#(
  parameter int p_num   = 4,
  parameter int p_idx_w = 2
) (
  input  logic [p_num-1:0]   i_req,
  input  logic [p_idx_w-1:0] i_ptr,
  output logic [p_num-1:0]   o_pick,
  output logic [p_idx_w-1:0] o_idx,
  output logic               o_any
);

  logic found;

  always_comb begin
    o_pick = '0;
    o_idx  = '0;
    found  = 1'b0;
    for (int k = 0; k < p_num; k++) begin
      if (!found && i_req[rr_wrap(int'(i_ptr), k, p_num)]) begin
        found = 1'b1;
        o_idx = p_idx_w'(rr_wrap(int'(i_ptr), k, p_num));
        o_pick[rr_wrap(int'(i_ptr), k, p_num)] = 1'b1;
      end
    end
    o_any = found;
  end

endmodule

// File: rtl/x_top_uart_tx_arb.sv
// x_top_uart_tx_arb
//   Shares one UART transmitter between p_num_req byte requesters with
//   per-byte round-robin arbitration and an optional per-requester lock that
//   keeps the grant for multi-byte messages. The granted byte is captured in
//   a holding register that stays stable for the whole frame.
// Ports
//   i_clk          in   1            clock
//   i_nrst         in   1            asynchronous active-low reset
//   i_req_valid    in   p_num_req    requester n has a byte on i_req_data[8n+:8]
//   i_req_data     in   8*p_num_req  flattened request bytes
//   i_req_lock     in   p_num_req    keep the grant with requester n after its byte
//   o_req_accept   out  p_num_req    one-hot pulse, byte taken
//   o_uart_data    out  8            byte for the UART TX, stable while valid
//   o_uart_valid   out  1            frame request to the UART TX
//   i_uart_accept  in   1            UART TX finished the frame
//   o_busy         out  1            frame in flight
//   o_grant_id     out  p_id_width   index of the last granted requester
//
// state | meaning
// ARB   | choose a requester; accept pulse and byte capture happen here
// SEND  | hold byte on the UART interface until the frame completes
module x_top_uart_tx_arb
  import x_top_uart_pkg::*;
#(
  parameter int p_num_req  = 4,
  parameter int p_id_width = (p_num_req > 1) ? $clog2(p_num_req) : 1
) (
  input  logic                   i_clk,
  input  logic                   i_nrst,
  input  logic [p_num_req-1:0]   i_req_valid,
  input  logic [8*p_num_req-1:0] i_req_data,
  input  logic [p_num_req-1:0]   i_req_lock,
  output logic [p_num_req-1:0]   o_req_accept,
  output logic [7:0]             o_uart_data,
  output logic                   o_uart_valid,
  input  logic                   i_uart_accept,
  output logic                   o_busy,
  output logic [p_id_width-1:0]  o_grant_id
);

  localparam logic [p_id_width-1:0] c_last_id = p_id_width'(p_num_req - 1);

  sm_arb_t               state_q, state_d;
  logic [p_id_width-1:0] ptr_q, ptr_d;
  logic [p_id_width-1:0] lock_id_q, lock_id_d;
  logic [p_id_width-1:0] grant_id_q, grant_id_d;
  logic                  lock_vld_q, lock_vld_d;
  byte_t                 hold_q, hold_d;

  logic [p_num_req-1:0]  rr_pick;
  logic [p_id_width-1:0] rr_idx;
  logic                  rr_any;

  logic                  grant;
  logic [p_id_width-1:0] gnt_idx;
  logic                  lock_owner_valid;
  logic                  lock_hold;

  x_top_rr_pick #(
    .p_num   (p_num_req),
    .p_idx_w (p_id_width)
  ) u_rr_pick (
    .i_req  (i_req_valid),
    .i_ptr  (ptr_q),
    .o_pick (rr_pick),
    .o_idx  (rr_idx),
    .o_any  (rr_any)
  );

  assign lock_owner_valid = lock_vld_q && i_req_valid[lock_id_q];
  // Locked owner idle but still asserting lock: everybody else waits.
  assign lock_hold        = lock_vld_q && i_req_lock[lock_id_q];

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_q    <= ARB;
      ptr_q      <= '0;
      lock_vld_q <= 1'b0;
      lock_id_q  <= '0;
      grant_id_q <= '0;
      hold_q     <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      lock_vld_q <= lock_vld_d;
      lock_id_q  <= lock_id_d;
      grant_id_q <= grant_id_d;
      hold_q     <= hold_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    lock_vld_d   = lock_vld_q;
    lock_id_d    = lock_id_q;
    grant_id_d   = grant_id_q;
    hold_d       = hold_q;
    grant        = 1'b0;
    gnt_idx      = '0;
    o_req_accept = '0;

    case (state_q)
      ARB: begin
        if (lock_owner_valid) begin
          grant   = 1'b1;
          gnt_idx = lock_id_q;
        end else if (!lock_hold) begin
          // Lock released (or never held): round-robin may win this same cycle.
          lock_vld_d = 1'b0;
          if (rr_any) begin
            grant   = 1'b1;
            gnt_idx = rr_idx;
          end
        end

        if (grant) begin
          o_req_accept[gnt_idx] = 1'b1;
          hold_d     = i_req_data[8*gnt_idx +: 8];
          grant_id_d = gnt_idx;
          ptr_d      = (gnt_idx == c_last_id) ? '0 : gnt_idx + 1'b1;
          lock_vld_d = i_req_lock[gnt_idx];
          lock_id_d  = gnt_idx;
          state_d    = SEND;
        end
      end
      SEND: begin
        if (i_uart_accept) state_d = ARB;
      end
      default: state_d = ARB;
    endcase
  end

  assign o_uart_valid = (state_q == SEND);
  assign o_busy       = (state_q == SEND);
  assign o_uart_data  = hold_q;
  assign o_grant_id   = grant_id_q;

endmodule
